// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Level the serial line rests at between frames (and during reset).
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_block_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last count.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic clear,
    output logic rollover
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear wins, otherwise advance and wrap at the last count.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign rollover = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, DATA_BITS data LSB-first, optional even parity, stop bit.
// Every output is a flop loaded with the value belonging to the next state, so the
// line changes exactly on the edge that enters each bit.
module uart_tx_block
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 parity_q, parity_d;
    logic                 tx_out_q, tx_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 bit_roll;
    logic                 accept;
    logic                 last_bit;

    assign accept   = (state_q == IDLE) && tx_start;
    assign last_bit = (bit_idx_q == LAST_BIT);

    // The timer only runs inside a frame; holding it cleared in IDLE keeps
    // every frame's first bit exactly CLKS_PER_BIT long.
    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .enable  (state_q != IDLE),
        .clear   (state_q == IDLE),
        .rollover(bit_roll)
    );

    // State and registered outputs; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            tx_out_q <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state: each non-idle state lasts whole bit periods.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (tx_start) state_d = START;
            START:  if (bit_roll) state_d = DATA;
            DATA:   if (bit_roll && last_bit) state_d = PARITY_EN ? PARITY : STOP;
            PARITY: if (bit_roll) state_d = STOP;
            STOP:   if (bit_roll) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the cycle after this edge, derived from the next state.
    always_comb begin
        tx_out_d = IDLE_LEVEL;
        unique case (state_d)
            IDLE:   tx_out_d = IDLE_LEVEL;
            START:  tx_out_d = ~IDLE_LEVEL;
            DATA:   tx_out_d = shift_d[0];
            PARITY: tx_out_d = parity_q;
            STOP:   tx_out_d = IDLE_LEVEL;
            default: tx_out_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && bit_roll;
    end

    // Datapath next values: capture on accept, shift after each data bit.
    always_comb begin
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        if (accept) begin
            shift_d  = tx_data;
            parity_d = ^tx_data;
        end else if ((state_q == DATA) && bit_roll) begin
            shift_d   = shift_q >> 1;
            bit_idx_d = last_bit ? '0 : bit_idx_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// Bench for uart_tx_block: one instance without parity, one with parity.
// A frame-level model predicts the line, busy and done every cycle; directed
// tests add literal expectations for bit patterns and timing.
module tb_uart_tx_block;

    localparam int C = 10;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    wire        txo0, bsy0, dn0, txo1, bsy1, dn1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_block #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .tx_start(start0), .tx_data(data0),
        .tx_out(txo0), .tx_busy(bsy0), .tx_done(dn0)
    );

    uart_tx_block #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .tx_start(start1), .tx_data(data1),
        .tx_out(txo1), .tx_busy(bsy1), .tx_done(dn1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit         m_busy[2];
    bit         m_done[2];
    int         m_age[2];
    int         m_nbits[2];
    logic [15:0] m_frame[2];
    logic       p_start[2];
    logic [7:0] p_data[2];

    // Frame as a list of line levels: start, data LSB first, [parity], stop.
    function automatic logic [15:0] build(input logic [7:0] d, input bit par);
        logic [15:0] f = '0;
        int n = 0;
        f[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin f[n] = d[i]; n++; end
        if (par) begin f[n] = ^d; n++; end
        f[n] = 1'b1;
        return f;
    endfunction

    // At each falling edge: account for the rising edge just passed, then compare.
    always @(negedge clk) begin
        logic [2:0] act, exp;
        for (int i = 0; i < 2; i++) begin
            if (!n_rst) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                if (m_busy[i]) begin
                    m_age[i]++;
                    if (m_age[i] == m_nbits[i] * C) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end else if (p_start[i]) begin
                    m_busy[i]  = 1'b1;
                    m_age[i]   = 0;
                    m_nbits[i] = (i == 1) ? 11 : 10;
                    m_frame[i] = build(p_data[i], i == 1);
                end
            end
            if (cmp_en) begin
                act = (i == 0) ? {txo0, bsy0, dn0} : {txo1, bsy1, dn1};
                exp[2] = m_busy[i] ? m_frame[i][m_age[i] / C] : 1'b1;
                exp[1] = m_busy[i];
                exp[0] = m_done[i];
                chk($sformatf("model%0d {out,busy,done}", i), 32'(act), 32'(exp));
            end
        end
        p_start[0] = start0; p_data[0] = data0;
        p_start[1] = start1; p_data[1] = data1;
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input int inst, input logic [7:0] d);
        @(posedge clk); #1;
        if (inst == 0) begin start0 = 1'b1; data0 = d; end
        else           begin start1 = 1'b1; data1 = d; end
        @(posedge clk); #1;
        if (inst == 0) start0 = 1'b0; else start1 = 1'b0;
    endtask

    // Observes cycles E..E+F after an accept edge E (call right after it).
    task automatic capture(input int inst, input int nb, output logic [15:0] bits,
                           output int busy_cnt, output int done_at, output int n_done,
                           output int t0);
        logic o, b, d;
        bits = '0; busy_cnt = 0; done_at = -1; n_done = 0; t0 = -1;
        for (int j = 0; j <= nb * C; j++) begin
            @(negedge clk);
            o = (inst == 0) ? txo0 : txo1;
            b = (inst == 0) ? bsy0 : bsy1;
            d = (inst == 0) ? dn0  : dn1;
            if (b) busy_cnt++;
            if (d) begin done_at = j; n_done++; end
            if (!o && t0 < 0) t0 = cyc;
            if ((j % C) == 5 && (j / C) < nb) bits[j / C] = o;
        end
    endtask

    initial begin
        logic [15:0] bits, bits2;
        int bc, da, nd, t0a, t0b, cnt;

        @(negedge clk);
        cmp_en = 1'b1;
        chk("reset tx_out", 32'(txo0), 32'd1);
        chk("reset busy",   32'(bsy0), 32'd0);
        chk("reset done",   32'(dn0),  32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        // Idle after reset with no request
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (txo0 && !bsy0 && !dn0 && txo1 && !bsy1 && !dn1) cnt++;
        end
        chk("idle 200 cycles", 32'(cnt), 32'd200);

        // A5, no parity
        send(0, 8'hA5);
        capture(0, 10, bits, bc, da, nd, t0a);
        chk("A5 line bits", 32'(bits), 32'(10'b1_10100101_0));
        chk("A5 busy cycles", 32'(bc), 32'd100);
        chk("A5 done at", 32'(da), 32'd100);
        chk("A5 done count", 32'(nd), 32'd1);
        repeat (5) @(negedge clk);

        // Parity instance: A5 -> parity 0, 01 -> parity 1
        send(1, 8'hA5);
        capture(1, 11, bits, bc, da, nd, t0a);
        chk("A5p line bits", 32'(bits), 32'(11'b1_0_10100101_0));
        chk("A5p parity bit", 32'(bits[9]), 32'd0);
        chk("A5p busy cycles", 32'(bc), 32'd110);
        chk("A5p done at", 32'(da), 32'd110);
        repeat (3) @(negedge clk);
        send(1, 8'h01);
        capture(1, 11, bits, bc, da, nd, t0a);
        chk("01p line bits", 32'(bits), 32'(11'b1_1_00000001_0));
        chk("01p parity bit", 32'(bits[9]), 32'd1);
        chk("01p busy cycles", 32'(bc), 32'd110);
        repeat (5) @(negedge clk);

        // tx_start held high; data switched mid-frame
        @(posedge clk); #1;
        start0 = 1'b1; data0 = 8'h3C;
        @(posedge clk); #1;
        fork
            capture(0, 10, bits, bc, da, nd, t0a);
            begin repeat (50) @(posedge clk); #1; data0 = 8'hC3; end
        join
        fork
            capture(0, 10, bits2, bc, da, nd, t0b);
            begin repeat (20) @(posedge clk); #1; start0 = 1'b0; end
        join
        chk("held 1st frame", 32'(bits), 32'(10'b1_00111100_0));
        chk("held 2nd frame", 32'(bits2), 32'(10'b1_11000011_0));
        chk("held frame spacing", 32'(t0b - t0a), 32'd101);
        chk("held 2nd busy", 32'(bc), 32'd100);
        repeat (5) @(negedge clk);

        // Mid-frame start with new data is ignored
        send(0, 8'h96);
        fork
            capture(0, 10, bits, bc, da, nd, t0a);
            begin
                repeat (30) @(posedge clk); #1;
                start0 = 1'b1; data0 = 8'hFF;
                @(posedge clk); #1;
                start0 = 1'b0;
            end
        join
        cnt = 0;
        repeat (20) begin @(negedge clk); if (dn0 || bsy0) cnt++; end
        chk("ignored start bits", 32'(bits), 32'(10'b1_10010110_0));
        chk("ignored start dones", 32'(nd), 32'd1);
        chk("ignored start no 2nd frame", 32'(cnt), 32'd0);

        // Reset during data bit 3 (frame bit 4), then a clean 55 frame
        send(0, 8'hFF);
        repeat (4 * C + 3) @(negedge clk);
        #2;
        chk("pre-reset line low-or-high", 32'(bsy0), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("async reset tx_out", 32'(txo0), 32'd1);
        chk("async reset busy", 32'(bsy0), 32'd0);
        chk("async reset done", 32'(dn0), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        send(0, 8'h55);
        capture(0, 10, bits, bc, da, nd, t0a);
        chk("post-reset 55 bits", 32'(bits), 32'(10'b1_01010101_0));
        chk("post-reset 55 busy", 32'(bc), 32'd100);
        chk("post-reset 55 done at", 32'(da), 32'd100);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_block.md
# uart_tx_block

Serial transmitter that converts a parallel byte into an asynchronous UART-style frame on a single line: one start bit, DATA_BITS data bits LSB-first, an optional even-parity bit, and one stop bit. It sits at the outbound edge of the design, opposite the receive path's input synchronizer. It accepts a word through a start/busy handshake and signals completion with a one-cycle done pulse. The output is fully registered so it can drive an asynchronous receiver directly.

## Interface
- CLKS_PER_BIT, 10: clk cycles per serial bit; legal range is 2 or more.
- DATA_BITS, 8: payload bits per frame; legal range is 5 to 9.
- PARITY_EN, 0: when 1, an even-parity bit is inserted after the data bits.
- clk  in  1  system clock.
- n_rst  in  1  reset; asynchronous, active-low.
- tx_start  in  1  request to send; sampled only while tx_busy=0.
- tx_data  in  DATA_BITS  payload; captured on the accepting edge.
- tx_out  out  1  serial line; idles high.
- tx_busy  out  1  high while a frame is in progress.
- tx_done  out  1  one-cycle pulse after the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - tx_out=1 and tx_busy=0.
  - If tx_start=1 at a clk edge, tx_data is loaded into the shift register and the FSM moves to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA
  - tx_out = shift_reg[0], held for CLKS_PER_BIT cycles; then shift right one bit.
  - After DATA_BITS bits, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx_out = XOR of the captured data (even parity), held for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE with tx_done=1 for exactly one cycle.
- Bit timer counts 0..CLKS_PER_BIT-1; the state or bit advances when the count equals CLKS_PER_BIT-1, and the timer wraps to 0.
- Bit index counts 0..DATA_BITS-1 and is cleared on leaving DATA.
- tx_start while busy is ignored: no queueing and no error indication.
- tx_data changes during a frame have no effect; the data is captured only at acceptance.
- Reset mid-frame aborts the frame immediately. tx_out returns high asynchronously, and no done pulse is produced.

## Timing
- Reset values:
  - tx_out=1, tx_busy=0, tx_done=0.
  - FSM state IDLE; timer, bit index and shift register all 0.
- Accept edge E: tx_out=0 and tx_busy=1 from E onward, i.e. starting the following cycle.
- Frame length is F = (1 + DATA_BITS + PARITY_EN + 1) * CLKS_PER_BIT cycles. tx_busy is high for exactly F cycles.
- At edge E+F: tx_busy=0 and tx_done=1 for that one cycle, and tx_out=1.
- tx_start=1 during the tx_done cycle is accepted.
  - Back-to-back frames are therefore spaced F+1 cycles apart.
  - The line sees one extra idle cycle between frames, which is permitted.
- Bit k of a frame, where start is k=0, occupies cycles E+k*CLKS_PER_BIT through E+(k+1)*CLKS_PER_BIT-1, with no jitter.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Structure
- Package uart_tx_pkg holds the state typedef `tx_state_t` (IDLE, START, DATA, PARITY, STOP) and the constant IDLE_LEVEL=1'b1.
- Sub-module tx_bit_timer is a parameterized rollover counter with inputs clk, n_rst, enable and clear, and output `rollover` (pulses at count CLKS_PER_BIT-1).
- The top level contains the FSM, the shift register, the bit index and the parity flop.

## Test plan
- Reset release with no start: tx_out=1, tx_busy=0 and tx_done=0 hold for 200 cycles.
- CLKS_PER_BIT=10, PARITY_EN=0, tx_data=8'hA5, one-cycle tx_start:
  - line carries 0,1,0,1,0,0,1,0,1,1, each for 10 cycles;
  - tx_busy is high for 100 cycles;
  - tx_done pulses once at cycle 100.
- PARITY_EN=1 with tx_data=8'hA5 gives a parity bit of 0; with tx_data=8'h01 it gives 1. tx_busy is high for 110 cycles.
- tx_start held high continuously with data 8'h3C then 8'hC3 (switched mid-frame):
  - the first frame sends only 8'h3C;
  - the second frame's start bit begins 101 cycles after the first.
- tx_start pulsed mid-frame with new data: ignored, the frame is unchanged, and exactly one tx_done occurs.
- n_rst asserted during data bit 3: tx_out goes to 1 without waiting for a clk edge and tx_busy goes to 0. After release, a new 8'h55 frame is transmitted correctly.
